zcr_frame_analyzer: RTL and testbench
=====================================

Name: zcr_frame_analyzer

Overview:
- Downstream consumer of the zero-crossing counter stage in the LPC front end.
- Takes the running crossing count and its valid strobe, and groups samples into fixed-length analysis frames.
- Per frame, computes the zero-crossing rate (ZCR), a coarse pitch period (FRAME_LEN / ZCR) and a voiced/unvoiced flag.
- Results feed the LPC frame parameter packer.

Parameters:
- FRAME_LEN, 160, valid samples per analysis frame (20 ms at 8 kHz); legal range 18..65535.
- UV_ZCR, 24, ZCR threshold; a frame with ZCR above it is unvoiced.
- HYST, 4, hysteresis margin on UV_ZCR; used only when ZCR_VUV_HYST_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- count_in  in  16  running crossing count from upstream; free-running, wraps modulo 2^16
- v_in  in  1  sample-valid strobe from upstream; count_in is current in the same cycle
- zcr  out  16  crossings in the last completed frame
- period  out  16  floor(FRAME_LEN / zcr) in samples; 0 when zcr = 0
- voiced  out  1  voiced decision for the last frame
- vout  out  1  one-cycle pulse when zcr/period/voiced update
- busy  out  1  high while the divider FSM is not IDLE
- overrun  out  1  sticky; a frame ended while the previous result was still being computed

Behaviour:
- Reset: zcr, period, voiced, vout, busy, overrun = 0; internal base = 0, samp_cnt = 0, FSM = IDLE.
- Reset is synchronous, wins over all other activity and aborts any division in progress; no vout is produced for the aborted frame.
- samp_cnt increments on every cycle with v_in = 1, independent of FSM state.
- Frame end: v_in = 1 and samp_cnt = FRAME_LEN-1. On that edge:
  - samp_cnt <= 0.
  - delta <= count_in - base, 16-bit modulo, so wrap-around of count_in is handled.
  - base <= count_in.
- FSM states: IDLE, DIV, DONE.
  - IDLE -> DIV at frame end when delta != 0.
  - IDLE -> DONE at frame end when delta = 0.
  - DIV: 16-iteration restoring division of FRAME_LEN (16-bit) by delta, one quotient bit per cycle, MSB first; after iteration 16 -> DONE.
  - DONE: register zcr, period and voiced; vout = 1 for exactly one cycle; -> IDLE.
- Latency:
  - delta != 0: vout is high in the cycle following the 17th rising edge after the frame-end edge.
  - delta = 0: vout is high in the cycle following the 1st edge after the frame-end edge.
- delta = 0 result: period = 0 and voiced = 0.
- Frame end while FSM != IDLE:
  - overrun <= 1 (sticky until rst).
  - The new frame's result is dropped; base and samp_cnt still update normally.
  - The in-flight division completes unaffected.
- Voiced decision without hysteresis: voiced = (zcr != 0) and (zcr <= UV_ZCR).
- Outputs zcr, period and voiced hold their values between vout pulses.
- busy = (FSM != IDLE).
- v_in may be asserted every cycle; FRAME_LEN >= 18 guarantees no overrun under that load.

Optional Feature:
- Macro: ZCR_VUV_HYST_EN.
- Defined: the decision depends on the previous voiced value (reset value 0).
  - Previously voiced: stays voiced while zcr != 0 and zcr <= UV_ZCR + HYST.
  - Previously unvoiced: becomes voiced only if zcr != 0 and zcr <= UV_ZCR - HYST.
  - UV_ZCR - HYST saturates at 0.
- Undefined: the plain threshold rule above; HYST is unused.

Test Plan:
- Defaults; v_in every 2 cycles; count_in increments once every 8 valid samples from 0 -> zcr = 20, period = 8, voiced = 1, vout pulses once per frame, overrun = 0.
- Defaults; count_in held constant -> zcr = 0, period = 0, voiced = 0, vout 2 edges after frame end, FSM never enters DIV.
- Wrap: base = 0xFFF0 and count_in = 0x0010 at frame end -> zcr = 32, period = 5, voiced = 0.
- Overrun: FRAME_LEN = 16 override, v_in every cycle, count_in incrementing -> overrun = 1 on the second frame end; the first frame's vout still occurs; zcr does not update for the dropped frame.
- Hysteresis: frame ZCRs 20, 27, 29, 22, 19 (UV_ZCR = 24, HYST = 4):
  - With ZCR_VUV_HYST_EN: voiced = 1, 1, 0, 0, 1.
  - Without: voiced = 1, 0, 0, 1, 1.
- Reset mid-DIV: assert rst 5 cycles after frame end -> no vout; all outputs 0; next full frame produces a correct result with base = 0.

Source files
------------

// File: rtl/zcr_frame_analyzer_if.sv
// Bus between the zero-crossing counter stage and the frame analyzer:
// running count plus valid strobe in, per-frame results and status out.
interface zcr_frame_analyzer_if;
    logic [15:0] count_in;
    logic        v_in;
    logic [15:0] zcr;
    logic [15:0] period;
    logic        voiced;
    logic        vout;
    logic        busy;
    logic        overrun;

    modport master (
        output count_in, v_in,
        input  zcr, period, voiced, vout, busy, overrun
    );

    modport slave (
        input  count_in, v_in,
        output zcr, period, voiced, vout, busy, overrun
    );
endinterface

// File: rtl/zcr_frame_analyzer.sv
// Zero-crossing frame analyzer: groups valid samples into FRAME_LEN frames,
// reports crossings per frame (zcr), coarse pitch period FRAME_LEN/zcr via a
// bit-serial restoring divider, and a voiced/unvoiced flag.
// Optional macro ZCR_VUV_HYST_EN adds hysteresis (HYST) to the voiced decision.
module zcr_frame_analyzer #(
    parameter int unsigned FRAME_LEN = 160,
    parameter int unsigned UV_ZCR    = 24,
    parameter int unsigned HYST      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    zcr_frame_analyzer_if.slave  bus
);
    localparam logic [15:0] FL      = 16'(FRAME_LEN);
    localparam logic [15:0] FL_LAST = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] base;
    logic [15:0] samp_cnt;
    logic [15:0] delta;
    logic [15:0] dvd;
    logic [15:0] quot;
    logic [15:0] rem;
    logic [3:0]  bit_cnt;
    logic        frame_end;
    logic [15:0] diff;
    logic [16:0] rem_sh;
    logic        fits;
    logic        voiced_nxt;

    assign frame_end = bus.v_in && (samp_cnt == FL_LAST);
    assign diff      = bus.count_in - base;
    assign rem_sh    = {rem, dvd[15]};
    assign fits      = (rem_sh >= {1'b0, delta});
    assign bus.busy  = (state != IDLE);

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: start a division at frame end, skip it when no crossings.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_end) state_nxt = (diff != '0) ? DIV : DONE;
            DIV:     if (bit_cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sample counter and frame base track every valid sample, even when busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
            base     <= '0;
        end else if (bus.v_in) begin
            if (frame_end) begin
                samp_cnt <= '0;
                base     <= bus.count_in;
            end else begin
                samp_cnt <= samp_cnt + 16'd1;
            end
        end
    end

    // Restoring divider FRAME_LEN / delta, one quotient bit per cycle, MSB first.
    // delta is only captured in IDLE so a dropped frame cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            delta   <= '0;
            dvd     <= '0;
            quot    <= '0;
            rem     <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            if (frame_end) begin
                delta   <= diff;
                dvd     <= FL;
                quot    <= '0;
                rem     <= '0;
                bit_cnt <= '0;
            end
        end else if (state == DIV) begin
            dvd     <= {dvd[14:0], 1'b0};
            quot    <= {quot[14:0], fits};
            // true remainder is below delta, so 16-bit modular subtraction is exact
            rem     <= fits ? (rem_sh[15:0] - delta) : rem_sh[15:0];
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

`ifdef ZCR_VUV_HYST_EN
    localparam int unsigned VUV_HI = UV_ZCR + HYST;
    localparam int unsigned VUV_LO = (UV_ZCR > HYST) ? (UV_ZCR - HYST) : 0;

    // Voiced decision with hysteresis around UV_ZCR, keyed on the previous flag.
    always_comb begin
        voiced_nxt = 1'b0;
        if (delta != '0) begin
            if (bus.voiced) voiced_nxt = ({16'd0, delta} <= VUV_HI);
            else            voiced_nxt = ({16'd0, delta} <= VUV_LO);
        end
    end
`else
    // Voiced decision: some crossings, but no more than UV_ZCR.
    always_comb begin
        voiced_nxt = (delta != '0) && ({16'd0, delta} <= UV_ZCR);
    end
`endif

    // Result registers, one-cycle vout pulse, sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.zcr     <= '0;
            bus.period  <= '0;
            bus.voiced  <= 1'b0;
            bus.vout    <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.vout <= 1'b0;
            if (state == DONE) begin
                bus.zcr    <= delta;
                bus.period <= (delta == '0) ? '0 : quot;
                bus.voiced <= voiced_nxt;
                bus.vout   <= 1'b1;
            end
            if (frame_end && (state != IDLE)) bus.overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_zcr_frame_analyzer.sv
// Self-checking bench for zcr_frame_analyzer: table-driven frames on the
// default instance plus hand-written sequences (half-rate input, reset in
// the middle of a division, overrun on a FRAME_LEN=16 instance).
module tb_zcr_frame_analyzer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    zcr_frame_analyzer_if b ();
    zcr_frame_analyzer_if b16 ();

    zcr_frame_analyzer dut (.clk(clk), .rst(rst), .bus(b));
    zcr_frame_analyzer #(.FRAME_LEN(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    typedef struct {
        logic [15:0] end_cnt;
        logic [15:0] zcr;
        logic [15:0] period;
        logic        v_nh;
        logic        v_h;
    } vec_t;

    vec_t        vt [12];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses;
    logic [15:0] p_zcr [3];
    logic [15:0] p_per [3];
    logic        p_vcd [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b.v_in = 1'b0;
        b.count_in = '0;
        b16.v_in = 1'b0;
        b16.count_in = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // 160 valid samples, count held at hold except last at frame end
    task automatic do_frame(input logic [15:0] hold, input logic [15:0] last);
        for (int s = 0; s < 160; s++) begin
            b.v_in = 1'b1;
            b.count_in = (s == 159) ? last : hold;
            tick();
        end
        b.v_in = 1'b0;
    endtask

    task automatic wait_vout(output int n);
        n = 0;
        while (!b.vout && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_zcr"}, b.zcr, 0);
        check({tag, "_period"}, b.period, 0);
        check({tag, "_voiced"}, b.voiced, 0);
        check({tag, "_vout"}, b.vout, 0);
        check({tag, "_busy"}, b.busy, 0);
        check({tag, "_overrun"}, b.overrun, 0);
    endtask

    task automatic mon_default();
        if (b.vout) begin
            pulses++;
            check("half_rate_zcr", b.zcr, 20);
            check("half_rate_period", b.period, 8);
            check("half_rate_voiced", b.voiced, 1);
        end
    endtask

    task automatic mon16();
        if (b16.vout) begin
            if (pulses < 3) begin
                p_zcr[pulses] = b16.zcr;
                p_per[pulses] = b16.period;
                p_vcd[pulses] = b16.voiced;
            end
            pulses++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev;
        logic [15:0] prev_zcr;
        logic        exp_v;
        logic [15:0] c16;
        int          n;

        //            end_cnt  zcr     period  v_nh  v_h
        vt[0]  = '{16'd20,    16'd20,    16'd8,   1'b1, 1'b1};
        vt[1]  = '{16'd47,    16'd27,    16'd5,   1'b0, 1'b1};
        vt[2]  = '{16'd76,    16'd29,    16'd5,   1'b0, 1'b0};
        vt[3]  = '{16'd98,    16'd22,    16'd7,   1'b1, 1'b0};
        vt[4]  = '{16'd117,   16'd19,    16'd8,   1'b1, 1'b1};
        vt[5]  = '{16'd117,   16'd0,     16'd0,   1'b0, 1'b0};
        vt[6]  = '{16'hFFF0,  16'd65403, 16'd0,   1'b0, 1'b0};
        vt[7]  = '{16'h0010,  16'd32,    16'd5,   1'b0, 1'b0};
        vt[8]  = '{16'd17,    16'd1,     16'd160, 1'b1, 1'b1};
        vt[9]  = '{16'd177,   16'd160,   16'd1,   1'b0, 1'b0};
        vt[10] = '{16'd201,   16'd24,    16'd6,   1'b1, 1'b0};
        vt[11] = '{16'd226,   16'd25,    16'd6,   1'b0, 1'b0};

        // reset state
        do_reset();
        check_outputs_zero("reset");
        check("reset16_overrun", b16.overrun, 0);
        check("reset16_busy", b16.busy, 0);

        // half-rate input, count advances once per 8 valid samples
        pulses = 0;
        for (int k = 0; k < 320; k++) begin
            b.v_in = 1'b1;
            b.count_in = 16'((k + 1) / 8);
            tick();
            mon_default();
            b.v_in = 1'b0;
            tick();
            mon_default();
        end
        n = 0;
        while (pulses < 2 && n < 40) begin
            tick();
            mon_default();
            n++;
        end
        check("half_rate_pulses", pulses, 2);
        check("half_rate_overrun", b.overrun, 0);

        // table-driven frames from a clean base
        do_reset();
        check_outputs_zero("reset2");
        prev = '0;
        prev_zcr = '0;
        for (int i = 0; i < 12; i++) begin
`ifdef ZCR_VUV_HYST_EN
            exp_v = vt[i].v_h;
`else
            exp_v = vt[i].v_nh;
`endif
            do_frame(prev, vt[i].end_cnt);
            check("hold_zcr", b.zcr, prev_zcr);
            check("busy_after_end", b.busy, 1);
            wait_vout(n);
            check("latency", n, (vt[i].zcr == 0) ? 1 : 17);
            check("zcr", b.zcr, vt[i].zcr);
            check("period", b.period, vt[i].period);
            check("voiced", b.voiced, exp_v);
            tick();
            check("vout_one_cycle", b.vout, 0);
            check("busy_idle", b.busy, 0);
            check("overrun_clear", b.overrun, 0);
            prev = vt[i].end_cnt;
            prev_zcr = vt[i].zcr;
        end

        // reset five cycles into a division
        do_frame(prev, prev + 16'd40);
        check("pre_abort_busy", b.busy, 1);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (b.vout) n++;
            tick();
        end
        check("abort_no_vout", n, 0);
        check_outputs_zero("abort");
        do_frame(16'd0, 16'd30);
        wait_vout(n);
        check("abort_next_latency", n, 17);
        check("abort_next_zcr", b.zcr, 30);
        check("abort_next_period", b.period, 5);
        check("abort_next_voiced", b.voiced, 0);

        // overrun on FRAME_LEN=16 with v_in every cycle
        do_reset();
        pulses = 0;
        for (int k = 0; k < 48; k++) begin
            if (k < 16)      c16 = 16'(k + 1);
            else if (k < 32) c16 = 16'(16 + 3 * (k - 15));
            else if (k < 47) c16 = 16'd64;
            else             c16 = 16'd69;
            b16.v_in = 1'b1;
            b16.count_in = c16;
            tick();
            mon16();
            if (k == 15) check("ovr_first_end", b16.overrun, 0);
            if (k == 31) check("ovr_second_end", b16.overrun, 1);
        end
        b16.v_in = 1'b0;
        n = 0;
        while (pulses < 2 && n < 40) begin
            tick();
            mon16();
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            mon16();
        end
        check("ovr_pulses", pulses, 2);
        check("ovr_first_zcr", p_zcr[0], 16);
        check("ovr_first_period", p_per[0], 1);
        check("ovr_first_voiced", p_vcd[0], 1);
        check("ovr_third_zcr", p_zcr[1], 5);
        check("ovr_third_period", p_per[1], 3);
        check("ovr_third_voiced", p_vcd[1], 1);
        check("ovr_sticky", b16.overrun, 1);
        check("ovr_default_untouched", b.overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
